i2s_effect_ctrl: RTL and testbench

Control/sequencing block for the I2S effect datapath (receiver, effect core, transmitter) in the sclk_i domain. It watches ws_i for frame timing and locks to the frame structure. It detects framing errors, drives the sticky errorLED and issues a timed rstI2S_n resync pulse to the I2S receiver/transmitter. It debounces freqSetting_i/scaleFactor_i and applies new settings to the effect core only at a left-channel frame start.

---
 rtl/i2s_ctrl_pkg.sv | 19 +
 rtl/i2s_effect_ctrl_if.sv | 28 ++
 rtl/i2s_frame_monitor.sv | 45 ++++
 rtl/i2s_effect_ctrl.sv | 161 ++++++++++++++++
 tb/tb_i2s_effect_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_ctrl_pkg.sv
// rtl/i2s_ctrl_pkg.sv - shared types and reset defaults for the I2S effect controller
package i2s_ctrl_pkg;

    typedef enum logic [1:0] {
        ACQUIRE,
        LOCKING,
        RUN,
        RESYNC
    } ctrl_state_t;

    typedef struct packed {
        logic [3:0] freq;
        logic [3:0] scale;
    } cfg_t;

    localparam logic [3:0] DEF_RESET_FREQ  = 4'b0001;
    localparam logic [3:0] DEF_RESET_SCALE = 4'b0001;

endpackage

// File: rtl/i2s_effect_ctrl_if.sv
// rtl/i2s_effect_ctrl_if.sv - signal bundle between the controller and its surroundings
// Ports: ws_i, freqSetting_i, scaleFactor_i, clearErr_i driven by the master;
//        applied settings, pulses, status and I2S reset driven by the slave (controller).
interface i2s_effect_ctrl_if;
    logic       ws_i;
    logic [3:0] freqSetting_i;
    logic [3:0] scaleFactor_i;
    logic       clearErr_i;
    logic [3:0] freqSetting_o;
    logic [3:0] scaleFactor_o;
    logic       cfgUpdate_o;
    logic       frameStart_o;
    logic       locked_o;
    logic       errorLED;
    logic       rstI2S_n;

    modport master (
        output ws_i, freqSetting_i, scaleFactor_i, clearErr_i,
        input  freqSetting_o, scaleFactor_o, cfgUpdate_o, frameStart_o,
               locked_o, errorLED, rstI2S_n
    );

    modport slave (
        input  ws_i, freqSetting_i, scaleFactor_i, clearErr_i,
        output freqSetting_o, scaleFactor_o, cfgUpdate_o, frameStart_o,
               locked_o, errorLED, rstI2S_n
    );
endinterface

// File: rtl/i2s_frame_monitor.sv
// rtl/i2s_frame_monitor.sv - ws edge detection and half-frame length classification
// Ports: sclk_i, rst_n_i, ws_i in; ws_edge, good_edge, bad_edge, stall, fall_edge out
//        (all flags are combinational and valid in the cycle ws_i is sampled).
module i2s_frame_monitor #(
    parameter int WIDTH = 16
) (
    input  logic sclk_i,
    input  logic rst_n_i,
    input  logic ws_i,
    output logic ws_edge,
    output logic good_edge,
    output logic bad_edge,
    output logic stall,
    output logic fall_edge
);
    localparam int CW = $clog2(2 * WIDTH) + 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(2 * WIDTH);
    localparam logic [CW-1:0] CNT_GOOD  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_STALL = CW'(2 * WIDTH - 1);

    logic          ws_prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge sclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ws_prev <= 1'b0;
            cnt     <= '0;
        end else begin
            ws_prev <= ws_i;
            if (ws_edge)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CW'(1);
        end
    end

    assign ws_edge   = (ws_i != ws_prev);
    // cnt is one less than the cycles elapsed since the previous edge
    assign good_edge = ws_edge && (cnt == CNT_GOOD);
    assign bad_edge  = ws_edge && (cnt != CNT_GOOD);
    // fires once, on the cycle cnt would step onto its saturation value
    assign stall     = !ws_edge && (cnt == CNT_STALL);
    assign fall_edge = ws_edge && ws_prev;

endmodule

// File: rtl/i2s_effect_ctrl.sv
// rtl/i2s_effect_ctrl.sv - frame lock FSM, error/resync handling and settings debounce
// Ports: sclk_i (sole clock), rst_n_i (async active-low), bus (slave modport:
//        ws/switch/clear inputs; applied settings, cfgUpdate/frameStart pulses,
//        locked, errorLED and rstI2S_n outputs).
module i2s_effect_ctrl
    import i2s_ctrl_pkg::*;
#(
    parameter int         WIDTH         = 16,
    parameter int         STABLE_FRAMES = 4,
    parameter int         RESYNC_CYCLES = 8,
    parameter int         LOCK_EDGES    = 2,
    parameter logic [3:0] RESET_FREQ    = DEF_RESET_FREQ,
    parameter logic [3:0] RESET_SCALE   = DEF_RESET_SCALE
) (
    input logic              sclk_i,
    input logic              rst_n_i,
    i2s_effect_ctrl_if.slave bus
);
    localparam int GW = $clog2(LOCK_EDGES + 1);
    localparam int RW = $clog2(RESYNC_CYCLES + 1);
    localparam int SW = $clog2(STABLE_FRAMES + 1);

    logic ws_edge, good_edge, bad_edge, stall, fall_edge;

    i2s_frame_monitor #(.WIDTH(WIDTH)) u_monitor (
        .sclk_i    (sclk_i),
        .rst_n_i   (rst_n_i),
        .ws_i      (bus.ws_i),
        .ws_edge   (ws_edge),
        .good_edge (good_edge),
        .bad_edge  (bad_edge),
        .stall     (stall),
        .fall_edge (fall_edge)
    );

    ctrl_state_t   state_q, state_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic [RW-1:0] resync_cnt_q, resync_cnt_d;
    logic          rst_i2s_q, rst_i2s_d;
    logic          err_q, err_set;
    logic          frame_start_q, fs_evt;

    always_ff @(posedge sclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ACQUIRE;
            good_cnt_q    <= '0;
            resync_cnt_q  <= '0;
            rst_i2s_q     <= 1'b0;
            err_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            resync_cnt_q  <= resync_cnt_d;
            rst_i2s_q     <= rst_i2s_d;
            frame_start_q <= fs_evt;
            // a new error outranks a simultaneous clear request
            if (err_set)
                err_q <= 1'b1;
            else if (bus.clearErr_i)
                err_q <= 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        resync_cnt_d = resync_cnt_q;
        rst_i2s_d    = 1'b1;
        err_set      = 1'b0;
        fs_evt       = 1'b0;
        unique case (state_q)
            ACQUIRE: begin
                // the first edge only gives a timing reference; it is not judged
                if (ws_edge) begin
                    state_d    = LOCKING;
                    good_cnt_d = '0;
                end
            end
            LOCKING: begin
                if (good_edge) begin
                    if (good_cnt_q == GW'(LOCK_EDGES - 1)) begin
                        state_d    = RUN;
                        good_cnt_d = '0;
                        fs_evt     = fall_edge;
                    end else begin
                        good_cnt_d = good_cnt_q + GW'(1);
                    end
                end else if (bad_edge || stall) begin
                    good_cnt_d = '0;
                end
            end
            RUN: begin
                if (bad_edge || stall) begin
                    state_d      = RESYNC;
                    resync_cnt_d = '0;
                    rst_i2s_d    = 1'b0;
                    err_set      = 1'b1;
                end else begin
                    fs_evt = good_edge && fall_edge;
                end
            end
            RESYNC: begin
                if (resync_cnt_q == RW'(RESYNC_CYCLES - 1)) begin
                    state_d = ACQUIRE;
                end else begin
                    resync_cnt_d = resync_cnt_q + RW'(1);
                    rst_i2s_d    = 1'b0;
                end
            end
            default: state_d = ACQUIRE;
        endcase
    end

    // settings path: synchronise, debounce across frame starts, apply at a RUN frame start
    cfg_t          sync_meta_q, sync_q, prev_cand_q, applied_q;
    logic [SW-1:0] stable_q, stable_next;
    logic          cfg_update_q, apply;

    always_comb begin
        if (sync_q == prev_cand_q)
            stable_next = (stable_q == SW'(STABLE_FRAMES)) ? stable_q : stable_q + SW'(1);
        else
            stable_next = SW'(1);
        // the frame start that completes lock comes from LOCKING and is not used here
        apply = (state_q == RUN) && fs_evt && (sync_q != applied_q)
                && (stable_next == SW'(STABLE_FRAMES));
    end

    always_ff @(posedge sclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_meta_q  <= '0;
            sync_q       <= '0;
            prev_cand_q  <= '0;
            applied_q    <= '{freq: RESET_FREQ, scale: RESET_SCALE};
            stable_q     <= '0;
            cfg_update_q <= 1'b0;
        end else begin
            sync_meta_q  <= '{freq: bus.freqSetting_i, scale: bus.scaleFactor_i};
            sync_q       <= sync_meta_q;
            cfg_update_q <= apply;
            if (state_q != RUN) begin
                stable_q <= '0;
            end else if (fs_evt) begin
                stable_q    <= stable_next;
                prev_cand_q <= sync_q;
            end
            if (apply)
                applied_q <= sync_q;
        end
    end

    assign bus.freqSetting_o = applied_q.freq;
    assign bus.scaleFactor_o = applied_q.scale;
    assign bus.cfgUpdate_o   = cfg_update_q;
    assign bus.frameStart_o  = frame_start_q;
    assign bus.locked_o      = (state_q == RUN);
    assign bus.errorLED      = err_q;
    assign bus.rstI2S_n      = rst_i2s_q;

endmodule

// File: tb/tb_i2s_effect_ctrl.sv
// tb/tb_i2s_effect_ctrl.sv - self-checking bench for i2s_effect_ctrl
module tb_i2s_effect_ctrl;
    localparam int W  = 16;
    localparam int SF = 4;
    localparam int RC = 8;
    localparam int LE = 2;

    logic sclk = 1'b0;
    logic rst_n = 1'b0;
    always #5 sclk = ~sclk;

    i2s_effect_ctrl_if bus ();

    i2s_effect_ctrl #(
        .WIDTH(W), .STABLE_FRAMES(SF), .RESYNC_CYCLES(RC), .LOCK_EDGES(LE),
        .RESET_FREQ(4'b0001), .RESET_SCALE(4'b0001)
    ) dut (
        .sclk_i  (sclk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fs_cnt, upd_cnt, low_cnt, last_upd_fs;

    // reference model: time since last ws edge, lock progress, resync deadline,
    // two-sample switch history and a frame-start debounce count
    bit         m_seen, m_locked, m_resync, m_prev_ws;
    int         m_good, m_left, m_age, m_stable;
    logic [7:0] m_sync[$];
    logic [7:0] m_prev_sample, m_applied;
    bit         e_fs, e_upd, e_rst, e_led;

    task automatic model_reset();
        m_seen = 0; m_locked = 0; m_resync = 0; m_prev_ws = 0;
        m_good = 0; m_left = 0; m_age = 0; m_stable = 0;
        m_sync = '{8'h00, 8'h00};
        m_prev_sample = 8'h00; m_applied = 8'h11;
        e_fs = 0; e_upd = 0; e_rst = 0; e_led = 0;
    endtask

    task automatic model_step();
        bit ed, fall, good, bad, stl, err;
        logic [7:0] cand;
        m_age++;
        ed   = (bus.ws_i != m_prev_ws);
        fall = ed && !bus.ws_i;
        good = ed && (m_age == W);
        bad  = ed && !good;
        stl  = !ed && (m_age == 2 * W);
        if (ed) m_age = 0;
        m_prev_ws = bus.ws_i;
        cand = m_sync[0];
        void'(m_sync.pop_front());
        m_sync.push_back({bus.freqSetting_i, bus.scaleFactor_i});
        e_fs = 0; e_upd = 0; e_rst = 1; err = 0;
        if (m_resync) begin
            m_left--;
            if (m_left > 0) e_rst = 0; else m_resync = 0;
            m_stable = 0;
        end else if (!m_seen) begin
            if (ed) begin m_seen = 1; m_good = 0; end
            m_stable = 0;
        end else if (!m_locked) begin
            m_stable = 0;
            if (good) begin
                m_good++;
                if (m_good == LE) begin m_locked = 1; e_fs = fall; end
            end else if (bad || stl) begin
                m_good = 0;
            end
        end else begin
            if (bad || stl) begin
                m_locked = 0; m_seen = 0; m_resync = 1; m_left = RC;
                e_rst = 0; err = 1;
            end else if (good && fall) begin
                e_fs = 1;
                if (cand == m_prev_sample) m_stable = (m_stable < SF) ? m_stable + 1 : SF;
                else m_stable = 1;
                m_prev_sample = cand;
                if (cand != m_applied && m_stable >= SF) begin
                    m_applied = cand; e_upd = 1;
                end
            end
        end
        if (err) e_led = 1;
        else if (bus.clearErr_i) e_led = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic [12:0] act, exp;
        act = {bus.freqSetting_o, bus.scaleFactor_o, bus.cfgUpdate_o, bus.frameStart_o,
               bus.locked_o, bus.errorLED, bus.rstI2S_n};
        exp = {m_applied, e_upd, e_fs, m_locked, e_led, e_rst};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model cycle %0d: got {freq,scale,upd,fs,lock,led,rst}=%b expected %b",
                     cyc, act, exp);
        end
    endtask

    // one clock: model follows the same posedge the DUT sees, outputs compared on negedge
    task automatic tick();
        @(posedge sclk);
        cyc++;
        if (!rst_n) model_reset(); else model_step();
        @(negedge sclk);
        check_outputs();
        if (bus.frameStart_o) fs_cnt++;
        if (bus.cfgUpdate_o) begin upd_cnt++; last_upd_fs = fs_cnt; end
        if (!bus.rstI2S_n) low_cnt++;
    endtask

    task automatic half(input int len, input bit clr);
        bus.ws_i = ~bus.ws_i;
        bus.clearErr_i = clr;
        tick();
        bus.clearErr_i = 1'b0;
        repeat (len - 1) tick();
    endtask

    typedef struct {
        int len;
        bit clr;
        int exp_locked;
        int exp_err;
        int exp_low;
        int exp_fs;
    } vec_t;
    vec_t vecs[16];

    initial begin
        bus.ws_i = 1'b0;
        bus.freqSetting_i = 4'b0001;
        bus.scaleFactor_i = 4'b0001;
        bus.clearErr_i = 1'b0;
        model_reset();

        vecs[0]  = '{16, 0, 0, 0, 0, 0};
        vecs[1]  = '{16, 0, 0, 0, 0, 0};
        vecs[2]  = '{16, 0, 1, 0, 0, 0};
        vecs[3]  = '{16, 0, 1, 0, 0, 1};
        vecs[4]  = '{15, 0, 1, 0, 0, 0};
        vecs[5]  = '{16, 0, 0, 1, 8, 0};
        vecs[6]  = '{16, 0, 0, 1, 0, 0};
        vecs[7]  = '{16, 0, 0, 1, 0, 0};
        vecs[8]  = '{16, 0, 1, 1, 0, 0};
        vecs[9]  = '{16, 1, 1, 0, 0, 1};
        vecs[10] = '{41, 0, 0, 1, 8, 0};
        vecs[11] = '{16, 0, 0, 1, 0, 0};
        vecs[12] = '{16, 0, 0, 1, 0, 0};
        vecs[13] = '{16, 1, 1, 0, 0, 1};
        vecs[14] = '{10, 0, 1, 0, 0, 0};
        vecs[15] = '{16, 1, 0, 1, 8, 0};

        repeat (3) @(negedge sclk);
        chk("reset_outputs",
            int'({bus.freqSetting_o, bus.scaleFactor_o, bus.cfgUpdate_o, bus.frameStart_o,
                  bus.locked_o, bus.errorLED, bus.rstI2S_n}),
            int'({8'h11, 5'b00000}));
        rst_n = 1'b1;
        tick();
        chk("rst_i2s_after_release", int'(bus.rstI2S_n), 1);
        repeat (4) tick();

        // lock, short half-frame, stall, clear and clear-vs-error sequencing
        for (int i = 0; i < 16; i++) begin
            fs_cnt = 0; low_cnt = 0;
            half(vecs[i].len, vecs[i].clr);
            chk($sformatf("vec%0d_locked", i), int'(bus.locked_o), vecs[i].exp_locked);
            chk($sformatf("vec%0d_err", i), int'(bus.errorLED), vecs[i].exp_err);
            chk($sformatf("vec%0d_rst_low", i), low_cnt, vecs[i].exp_low);
            chk($sformatf("vec%0d_frame_starts", i), fs_cnt, vecs[i].exp_fs);
        end

        // frequency change applied on the 4th frame start after it is seen
        bus.clearErr_i = 1'b1; tick(); bus.clearErr_i = 1'b0;
        repeat (3) half(16, 0);
        chk("relock", int'(bus.locked_o), 1);
        repeat (3) half(16, 0);
        bus.freqSetting_i = 4'b0011;
        fs_cnt = 0; upd_cnt = 0; last_upd_fs = 0;
        repeat (12) half(16, 0);
        chk("freq_applied", int'(bus.freqSetting_o), 3);
        chk("freq_update_pulses", upd_cnt, 1);
        chk("freq_update_frame", last_upd_fs, 4);

        // scale toggling every frame never settles
        upd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            bus.scaleFactor_i = (i % 2) ? 4'b0100 : 4'b0001;
            half(16, 0);
            half(16, 0);
        end
        chk("scale_unchanged", int'(bus.scaleFactor_o), 1);
        chk("scale_no_pulse", upd_cnt, 0);
        chk("err_clean_run", int'(bus.errorLED), 0);
        bus.scaleFactor_i = 4'b0001;

        // randomized framing and switch activity against the model
        for (int i = 0; i < 300; i++) begin
            int r, len;
            r = $urandom_range(0, 99);
            len = (r < 90) ? 16 : (r < 94) ? 15 : (r < 97) ? 17 : 36;
            if ($urandom_range(0, 19) == 0) begin
                bus.freqSetting_i = 4'($urandom_range(0, 15));
                bus.scaleFactor_i = 4'($urandom_range(0, 15));
            end
            half(len, $urandom_range(0, 99) < 3);
        end

        // apply 1111, break framing, then reset in the middle of RESYNC
        repeat (40) tick();
        repeat (3) half(16, 0);
        chk("relock_before_reset", int'(bus.locked_o), 1);
        bus.freqSetting_i = 4'b1111;
        bus.scaleFactor_i = 4'b0001;
        repeat (14) half(16, 0);
        chk("freq_1111_applied", int'({bus.freqSetting_o, bus.scaleFactor_o}), 8'hF1);
        half(5, 0);
        bus.ws_i = ~bus.ws_i;
        repeat (3) tick();
        chk("in_resync_rst_low", int'(bus.rstI2S_n), 0);
        chk("in_resync_err", int'(bus.errorLED), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            int'({bus.freqSetting_o, bus.scaleFactor_o, bus.cfgUpdate_o, bus.frameStart_o,
                  bus.locked_o, bus.errorLED, bus.rstI2S_n}),
            int'({8'h11, 5'b00000}));
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_i2s_after_second_release", int'(bus.rstI2S_n), 1);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
